// File: rtl/addr_reg_ctrl_pkg.sv
// Shared types and constants for the address register stage and the
// address-source mux / control unit that drive it.
package addr_reg_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Address-source mux selects; shared so the control unit drives mux and AR consistently
  typedef enum logic [1:0] {
    MUX_INC  = 2'd0,
    MUX_JUMP = 2'd1,
    MUX_MAP  = 2'd2
  } addr_sel_t;

endpackage

// File: rtl/addr_reg_ctrl_lat_counter.sv
// Loadable down-counter for RAM read latency; term flags the last wait cycle.
module lat_counter #(
  parameter int MAX_CNT = 2,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && cnt != '0)     cnt <= cnt - CNT_W'(1);
  end

  assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/addr_reg_ctrl.sv
// Address register stage: AR load/increment, single RAM access sequencer, data register.
// Build option ADDR_REG_AUTO_INC_EN: AR steps by one after every completed access.
module addr_reg_ctrl
  import addr_reg_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic              ld,
  input  logic              inc,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ar_out,
  output logic [ADDR_W-1:0] inc_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] dr_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ar_q;
  logic [DATA_W-1:0] dr_q, wdata_q;
  logic              we_q;
  logic              en_q, we_pulse_q, done_q;
  logic              req_acc;
  logic              cnt_load, cnt_dec, cnt_term;
  logic [CNT_W-1:0]  cnt;

  assign req_acc  = (state_q == ST_IDLE) && mem_req;
  assign inc_addr = ar_q + ADDR_W'(1);
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE:   if (mem_req) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (we_q || RD_LAT == 1) state_d = ST_DONE;
        else begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_term) state_d = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  lat_counter #(
    .MAX_CNT (RD_LAT),
    .CNT_W   (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(RD_LAT - 1)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .term     (cnt_term)
  );

  // AR moves only in IDLE, so an access issued alongside ld/inc sees the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ar_q <= '0;
    else if (state_q == ST_IDLE) begin
      if (ld)       ar_q <= reg_in;
      else if (inc) ar_q <= inc_addr;
    end
`ifdef ADDR_REG_AUTO_INC_EN
    else if (state_q == ST_DONE) ar_q <= inc_addr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (req_acc) begin
      we_q    <= mem_we;
      wdata_q <= wdata;
    end
  end

  // Strobes are registered off the next state so they line up exactly with ACCESS/DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      we_pulse_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      en_q       <= (state_d == ST_ACCESS);
      we_pulse_q <= (state_d == ST_ACCESS) && mem_we;
      done_q     <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              dr_q <= '0;
    else if (state_d == ST_DONE && !we_q)    dr_q <= ram_rdata;
  end

  assign ar_out    = ar_q;
  assign ram_en    = en_q;
  assign ram_we    = we_pulse_q;
  assign ram_wdata = wdata_q;
  assign dr_out    = dr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_addr_reg_ctrl.sv
// Randomized bench for addr_reg_ctrl against a transaction-level model.
// Honours ADDR_REG_AUTO_INC_EN the same way the RTL build does.
module tb_addr_reg_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;
`ifdef ADDR_REG_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] reg_in;
  logic          ld, inc, mem_req, mem_we;
  logic [DW-1:0] wdata, ram_rdata;
  logic [AW-1:0] ar_out, inc_addr;
  logic          ram_en, ram_we, busy, done;
  logic [DW-1:0] ram_wdata, dr_out;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] exp_mem [256];
  logic [AW-1:0] ar_m;
  logic [DW-1:0] dr_m;

  always #5 clk = ~clk;

  addr_reg_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .reg_in(reg_in), .ld(ld), .inc(inc),
    .mem_req(mem_req), .mem_we(mem_we), .wdata(wdata), .ram_rdata(ram_rdata),
    .ar_out(ar_out), .inc_addr(inc_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .dr_out(dr_out), .busy(busy), .done(done)
  );

  // RAM: read data shows up after the enable edge and is held while busy; junk otherwise
  always @(posedge clk) begin
    if (ram_en && ram_we)       ram[ar_out[7:0]] <= ram_wdata;
    if (ram_en && !ram_we)      ram_rdata <= ram[ar_out[7:0]];
    else if (!busy)             ram_rdata <= DW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    logic [AW-1:0] nxt;
    nxt = ar_m + AW'(1);
    chk({tag, "_ar"}, ar_out, ar_m);
    chk({tag, "_inc_addr"}, inc_addr, nxt);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_en"}, ram_en, 1'b0);
    chk({tag, "_we"}, ram_we, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic idle_op(input logic l, input logic i, input logic [AW-1:0] rin);
    ld = l; inc = i; reg_in = rin;
    @(posedge clk); #1;
    ld = 1'b0; inc = 1'b0;
    if (l)      ar_m = rin;
    else if (i) ar_m = ar_m + AW'(1);
    chk_idle("idle");
  endtask

  // One access from IDLE; busy cycles carry random ld/inc/mem_req noise that must be ignored
  task automatic do_access(input logic we, input logic [DW-1:0] wd,
                           input logic l, input logic i, input logic [AW-1:0] rin,
                           output logic [AW-1:0] addr);
    int exp_done;
    mem_req = 1'b1; mem_we = we; wdata = wd; ld = l; inc = i; reg_in = rin;
    @(posedge clk); #1;
    if (l)      ar_m = rin;
    else if (i) ar_m = ar_m + AW'(1);
    addr = ar_m;
    exp_done = we ? 2 : RL + 1;
    for (int k = 1; k <= exp_done; k++) begin
      chk("acc_busy", busy, 1'b1);
      chk("acc_en", ram_en, k == 1);
      chk("acc_we", ram_we, (k == 1) && we);
      chk("acc_done", done, k == exp_done);
      chk("acc_ar_frozen", ar_out, addr);
      if (k == 1 && we) chk("acc_wdata", ram_wdata, wd);
      if (k == exp_done) begin
        if (!we) dr_m = exp_mem[addr[7:0]];
        chk("acc_dr", dr_out, dr_m);
      end
      mem_req = 1'(($urandom_range(0, 1)));
      mem_we  = 1'(($urandom_range(0, 1)));
      ld      = 1'(($urandom_range(0, 1)));
      inc     = 1'(($urandom_range(0, 1)));
      reg_in  = AW'($urandom);
      wdata   = DW'($urandom);
      @(posedge clk); #1;
    end
    mem_req = 1'b0; ld = 1'b0; inc = 1'b0;
    if (we) exp_mem[addr[7:0]] = wd;
    if (AUTO) ar_m = ar_m + AW'(1);
    chk_idle("post");
    chk("post_dr", dr_out, dr_m);
  endtask

  initial begin
    logic [AW-1:0] a, a0, a1, a2;
    rst_n = 1'b0; reg_in = '0; ld = 0; inc = 0; mem_req = 0; mem_we = 0; wdata = '0;
    for (int j = 0; j < 256; j++) begin
      ram[j] = DW'($urandom);
      exp_mem[j] = ram[j];
    end
    ram[8'h40] = 16'hBEEF; exp_mem[8'h40] = 16'hBEEF;
    ar_m = '0; dr_m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_dr", dr_out, 16'h0000);
    chk("rst_wdata", ram_wdata, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst_rel");

    idle_op(1'b1, 1'b0, 16'h00A5);
    idle_op(1'b0, 1'b1, 16'h0000);
    idle_op(1'b0, 1'b1, 16'h0000);
    chk("tp_ar_a7", ar_out, 16'h00A7);
    chk("tp_inc_a8", inc_addr, 16'h00A8);

    idle_op(1'b1, 1'b0, 16'hFFFF);
    chk("tp_inc_ffff", inc_addr, 16'h0000);
    idle_op(1'b0, 1'b1, 16'h0000);
    chk("tp_wrap", ar_out, 16'h0000);
    idle_op(1'b1, 1'b1, 16'h0010);
    chk("tp_ld_pri", ar_out, 16'h0010);

    idle_op(1'b1, 1'b0, 16'h0040);
    do_access(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, a);
    chk("tp_rd_addr", a, 16'h0040);
    chk("tp_rd_dr", dr_out, 16'hBEEF);

    idle_op(1'b1, 1'b0, 16'h0003);
    do_access(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, a);
    chk("tp_wr_dr_kept", dr_out, 16'hBEEF);
    chk("tp_wr_ram", ram[8'h03], 16'h1234);

    // reset pulse while the read is in WAIT
    idle_op(1'b1, 1'b0, 16'h0040);
    mem_req = 1'b1; mem_we = 1'b0;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", busy, 1'b1);
    chk("wait_en", ram_en, 1'b0);
    rst_n = 1'b0; #1;
    ar_m = '0; dr_m = '0;
    chk_idle("mid_rst");
    chk("mid_rst_dr", dr_out, 16'h0000);
    chk("mid_rst_wdata", ram_wdata, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk_idle("after_rst");
    end

    // streaming reads
    idle_op(1'b1, 1'b0, 16'h0100);
    do_access(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, a0);
    do_access(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, a1);
    do_access(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, a2);
    chk("strm_a0", a0, 16'h0100);
    chk("strm_a1", a1, AUTO ? 16'h0101 : 16'h0100);
    chk("strm_a2", a2, AUTO ? 16'h0102 : 16'h0100);
    chk("strm_ar", ar_out, AUTO ? 16'h0103 : 16'h0100);

    // random mix, including access issued together with ld/inc
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        idle_op(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                AW'($urandom_range(0, 511) | (($urandom_range(0, 7) == 0) ? 32'hFF00 : 32'h0)));
      else
        do_access(1'(($urandom_range(0, 1))), DW'($urandom),
                  1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 3) == 0)),
                  AW'($urandom), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/addr_reg_ctrl.md
Name: addr_reg_ctrl

Overview:
Address register (AR) stage directly downstream of the address-source mux.
- Latches the mux output `reg_in` into AR.
- Generates `inc_addr` (AR+1), which feeds back into the mux.
- Sequences single read/write accesses to the core's data RAM, with a fixed read latency.
- Latches read data into a data register (DR) for the core control unit.

Parameters:
ADDR_W, 16, width of AR, `reg_in`, `inc_addr` and the RAM address.
DATA_W, 16, RAM data width.
RD_LAT, 2, RAM read latency in cycles (≥1), counted from the cycle `ram_en` is high to the cycle `ram_rdata` is valid.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
reg_in  input  ADDR_W  address from the address-source mux
ld  input  1  load AR from `reg_in`
inc  input  1  AR <= AR+1
mem_req  input  1  start a RAM access (sampled in IDLE only)
mem_we  input  1  access type, sampled with `mem_req` (1 = write)
wdata  input  DATA_W  write data, sampled with `mem_req`
ram_rdata  input  DATA_W  RAM read data
ar_out  output  ADDR_W  AR value; drives the RAM address
inc_addr  output  ADDR_W  AR+1 mod 2^ADDR_W (combinational)
ram_en  output  1  RAM enable (registered)
ram_we  output  1  RAM write enable (registered)
ram_wdata  output  DATA_W  latched write data
dr_out  output  DATA_W  data register
busy  output  1  high while state ≠ IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, immediate), including mid-access: AR=0, DR=0, ram_wdata=0, ram_en=0, ram_we=0, done=0, state=IDLE, latency counter=0.
- AR update, IDLE only:
  - `ld` has priority over `inc`.
  - `inc` at all-ones wraps to 0.
  - `ld` and `inc` are ignored while busy; AR is frozen during an access.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE & mem_req → ACCESS. `wdata` and `mem_we` are latched on this edge.
  - If `ld` or `inc` is asserted in the same cycle, the access uses the updated AR.
  - ACCESS, exactly 1 cycle: ram_en=1; ram_we = latched we.
    - Write → DONE.
    - Read with RD_LAT=1 → DONE.
    - Read with RD_LAT>1 → WAIT, counter loaded with RD_LAT-1.
  - WAIT: ram_en=0; counter decrements each cycle; when counter reaches 1 → DONE.
  - DONE, exactly 1 cycle: done=1.
    - Read: DR <= `ram_rdata` on the edge entering DONE, so DR is valid while done=1.
    - Write: DR unchanged.
  - DONE → IDLE.
  - `mem_req` is accepted again in the IDLE cycle following DONE (no back-to-back acceptance in DONE).
- Timing:
  - Read total: request edge to done = RD_LAT+1 cycles.
  - Write total: request edge to done = 2 cycles.
- `mem_req` while busy: ignored, not queued.
- `ram_en` and `ram_we` are never high outside ACCESS.
- `inc_addr` tracks AR combinationally at all times, including during reset.

Optional Feature:
Macro ADDR_REG_AUTO_INC_EN.
- Defined: AR increments (with wrap) on the DONE→IDLE edge of every completed access. This supports streaming matrix row reads.
- Undefined: AR is unchanged by accesses.
- `ld`/`inc` behaviour is identical in both builds.

Decomposition:
Shared package holds:
- state enum (IDLE, ACCESS, WAIT, DONE)
- default ADDR_W and DATA_W constants
- mux select encodings (INC=0, JUMP=1, MAP=2), so the control unit drives both blocks consistently

One natural sub-module: `lat_counter` (loadable down-counter with terminal flag), sized by clog2(RD_LAT+1).

Test Plan:
- Reset then idle → ar_out=0, inc_addr=1, busy=0, all RAM strobes 0.
- ld with reg_in=0x00A5, then inc ×2 → ar_out=0x00A7, inc_addr=0x00A8.
- AR=0xFFFF, inc → ar_out=0x0000. Also, ld and inc together with reg_in=0x0010 → ar_out=0x0010.
- Read with RD_LAT=2, AR=0x0040, RAM model returns 0xBEEF → ram_en high for 1 cycle; done 3 cycles after the req edge; dr_out=0xBEEF; a req during busy is ignored.
- Write with AR=0x0003, wdata=0x1234 → ram_en=ram_we=1 for exactly 1 cycle with ram_wdata=0x1234; done at +2; DR unchanged. Repeat the read with rst_n pulsed during WAIT → state IDLE and ram_en=0 immediately, done is never asserted.
- With ADDR_REG_AUTO_INC_EN, 3 consecutive reads from 0x0100 → addresses 0x0100, 0x0101, 0x0102 presented; AR ends at 0x0103. Without the macro, AR stays 0x0100.
